// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: two-requester TLP arbiter feeding one FPGA->Host pipe.
// A packet, once its SOP beat is accepted, owns the pipe until its EOP beat
// is accepted, so beats of two packets never interleave. The IDLE-state
// selection is combinational, which lets an SOP beat pass through in the
// same cycle it is presented.
// Optional per-requester packet counters are compiled in by defining the
// macro TLP_TX_ARB_STATS_EN. Without it the count ports are tied to zero.
`timescale 1ns/1ps

module tlp_tx_arbiter #(
    parameter bit PRIO0 = 1'b0   // 1: requester 0 strict priority, 0: round-robin
) (
    input  logic        pcieClk_in,
    input  logic        reset_in,
    input  logic [63:0] req0Data_in,
    input  logic        req0SOP_in,
    input  logic        req0EOP_in,
    input  logic        req0Valid_in,
    output logic        req0Ready_out,
    input  logic [63:0] req1Data_in,
    input  logic        req1SOP_in,
    input  logic        req1EOP_in,
    input  logic        req1Valid_in,
    output logic        req1Ready_out,
    output logic [63:0] txData_out,
    output logic        txSOP_out,
    output logic        txEOP_out,
    output logic        txValid_out,
    input  logic        txReady_in,
    output logic [15:0] pktCount0_out,
    output logic [15:0] pktCount1_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_grant;       // requester granted most recently
    logic   w_next_last_grant;

    logic w_elig0;
    logic w_elig1;
    logic w_sel0;
    logic w_sel1;
    logic w_sel_valid;
    logic w_sel_eop;
    logic w_accept;
    logic w_accept_eop;

    // A requester may start a packet only with a valid SOP beat.
    assign w_elig0 = req0Valid_in & req0SOP_in;
    assign w_elig1 = req1Valid_in & req1SOP_in;

    // Choose which requester is connected to the pipe this cycle.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel0 = 1'b0;
        w_sel1 = 1'b0;
        // Selection is suppressed during reset so all outputs read zero at once.
        if (!reset_in) begin
            case (r_state)
                ST_OWN0: w_sel0 = 1'b1;
                ST_OWN1: w_sel1 = 1'b1;
                default: begin
                    if (w_elig0 && w_elig1) begin
                        // Tie: fixed priority, or alternate away from the last winner.
                        if (PRIO0 || r_last_grant) begin
                            w_sel0 = 1'b1;
                        end else begin
                            w_sel1 = 1'b1;
                        end
                    end else begin
                        w_sel0 = w_elig0;
                        w_sel1 = w_elig1;
                    end
                end
            endcase
        end
    end

    assign w_sel_valid  = (w_sel0 & req0Valid_in) | (w_sel1 & req1Valid_in);
    assign w_sel_eop    = (w_sel0 & req0EOP_in)   | (w_sel1 & req1EOP_in);
    assign w_accept     = w_sel_valid & txReady_in;
    assign w_accept_eop = w_accept & w_sel_eop;

    assign txValid_out   = w_sel_valid;
    assign txSOP_out     = (w_sel0 & req0SOP_in) | (w_sel1 & req1SOP_in);
    assign txEOP_out     = w_sel_eop;
    assign txData_out    = ({64{w_sel0}} & req0Data_in) | ({64{w_sel1}} & req1Data_in);
    assign req0Ready_out = txReady_in & w_sel0;
    assign req1Ready_out = txReady_in & w_sel1;
    assign busy_out      = !reset_in && (r_state != ST_IDLE);

    // Next ownership state and last-grant tracking.
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_last_grant = w_sel1;
                    // A single-beat packet leaves the pipe free for the next cycle.
                    if (!w_sel_eop) begin
                        w_next_state = w_sel1 ? ST_OWN1 : ST_OWN0;
                    end
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_accept_eop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; reset abandons any packet in flight.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;   // requester 0 wins the first tie
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

`ifdef TLP_TX_ARB_STATS_EN
    logic [15:0] r_pkt_count0;
    logic [15:0] r_pkt_count1;

    // Count completed packets per requester; counters wrap naturally.
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            r_pkt_count0 <= 16'd0;
            r_pkt_count1 <= 16'd0;
        end else begin
            if (w_accept_eop && w_sel0) r_pkt_count0 <= r_pkt_count0 + 16'd1;
            if (w_accept_eop && w_sel1) r_pkt_count1 <= r_pkt_count1 + 16'd1;
        end
    end

    assign pktCount0_out = r_pkt_count0;
    assign pktCount1_out = r_pkt_count1;
`else
    assign pktCount0_out = 16'd0;
    assign pktCount1_out = 16'd0;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter. Two instances share all inputs: one
// round-robin (PRIO0=0) and one strict-priority (PRIO0=1); sel_dut picks
// which instance's outputs are compared and which Ready paces the sources.
// Each source replays a generated beat stream and advances on handshake.
`timescale 1ns/1ps

module tb_tlp_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic [63:0] req0Data_in, req1Data_in;
    logic        req0SOP_in, req0EOP_in, req0Valid_in;
    logic        req1SOP_in, req1EOP_in, req1Valid_in;
    logic        txReady_in;

    logic [63:0] a_data, p_data;
    logic        a_sop, a_eop, a_valid, a_rdy0, a_rdy1, a_busy;
    logic        p_sop, p_eop, p_valid, p_rdy0, p_rdy1, p_busy;
    logic [15:0] a_cnt0, a_cnt1, p_cnt0, p_cnt1;

    tlp_tx_arbiter #(.PRIO0(1'b0)) dut (
        .pcieClk_in(clk), .reset_in(reset_in),
        .req0Data_in(req0Data_in), .req0SOP_in(req0SOP_in), .req0EOP_in(req0EOP_in),
        .req0Valid_in(req0Valid_in), .req0Ready_out(a_rdy0),
        .req1Data_in(req1Data_in), .req1SOP_in(req1SOP_in), .req1EOP_in(req1EOP_in),
        .req1Valid_in(req1Valid_in), .req1Ready_out(a_rdy1),
        .txData_out(a_data), .txSOP_out(a_sop), .txEOP_out(a_eop), .txValid_out(a_valid),
        .txReady_in(txReady_in), .pktCount0_out(a_cnt0), .pktCount1_out(a_cnt1),
        .busy_out(a_busy)
    );

    tlp_tx_arbiter #(.PRIO0(1'b1)) dut_prio (
        .pcieClk_in(clk), .reset_in(reset_in),
        .req0Data_in(req0Data_in), .req0SOP_in(req0SOP_in), .req0EOP_in(req0EOP_in),
        .req0Valid_in(req0Valid_in), .req0Ready_out(p_rdy0),
        .req1Data_in(req1Data_in), .req1SOP_in(req1SOP_in), .req1EOP_in(req1EOP_in),
        .req1Valid_in(req1Valid_in), .req1Ready_out(p_rdy1),
        .txData_out(p_data), .txSOP_out(p_sop), .txEOP_out(p_eop), .txValid_out(p_valid),
        .txReady_in(txReady_in), .pktCount0_out(p_cnt0), .pktCount1_out(p_cnt1),
        .busy_out(p_busy)
    );

`ifdef TLP_TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    bit sel_dut = 1'b0;

    wire [63:0] obs_data  = sel_dut ? p_data  : a_data;
    wire        obs_sop   = sel_dut ? p_sop   : a_sop;
    wire        obs_eop   = sel_dut ? p_eop   : a_eop;
    wire        obs_valid = sel_dut ? p_valid : a_valid;
    wire        obs_rdy0  = sel_dut ? p_rdy0  : a_rdy0;
    wire        obs_rdy1  = sel_dut ? p_rdy1  : a_rdy1;
    wire        obs_busy  = sel_dut ? p_busy  : a_busy;
    wire [15:0] obs_cnt0  = sel_dut ? p_cnt0  : a_cnt0;
    wire [15:0] obs_cnt1  = sel_dut ? p_cnt1  : a_cnt1;

    // Source model: beat k of requester r has data base+k; packets are plen beats.
    int          s_plen [2];
    int          s_n    [2];
    int          s_idx  [2];
    logic [63:0] s_base [2];
    bit          s_nosop[2];
    bit          s_fire [2];
    bit          rst;
    bit          tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int r, input int plen, input int n,
                        input logic [63:0] base, input bit nosop);
        s_plen[r]  = plen;
        s_n[r]     = n;
        s_idx[r]   = 0;
        s_base[r]  = base;
        s_nosop[r] = nosop;
        s_fire[r]  = 1'b0;
    endtask

    task automatic drive();
        logic        v, s, e;
        logic [63:0] d;
        for (int r = 0; r < 2; r++) begin
            v = 1'b0; s = 1'b0; e = 1'b0; d = '0;
            if (s_idx[r] < s_n[r]) begin
                v = 1'b1;
                d = s_base[r] + 64'(s_idx[r]);
                s = !s_nosop[r] && (s_idx[r] % s_plen[r] == 0);
                e = (s_idx[r] % s_plen[r] == s_plen[r] - 1);
            end
            if (r == 0) begin
                req0Valid_in = v; req0SOP_in = s; req0EOP_in = e; req0Data_in = d;
            end else begin
                req1Valid_in = v; req1SOP_in = s; req1EOP_in = e; req1Data_in = d;
            end
        end
        reset_in   = rst;
        txReady_in = tx_ready;
    endtask

    // One cycle: advance sources that handshook, drive, settle, record handshakes.
    task automatic tick();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (s_fire[r]) s_idx[r]++;
        end
        drive();
        #1;
        s_fire[0] = req0Valid_in && obs_rdy0;
        s_fire[1] = req1Valid_in && obs_rdy1;
    endtask

    task automatic expect_tx(input string tag, input bit v, input bit s, input bit e,
                             input logic [63:0] d, input bit r0, input bit r1, input bit busy);
        check({tag, ".valid"}, 64'(obs_valid), 64'(v));
        check({tag, ".sop"},   64'(obs_sop),   64'(s));
        check({tag, ".eop"},   64'(obs_eop),   64'(e));
        check({tag, ".data"},  obs_data,       d);
        check({tag, ".rdy0"},  64'(obs_rdy0),  64'(r0));
        check({tag, ".rdy1"},  64'(obs_rdy1),  64'(r1));
        check({tag, ".busy"},  64'(obs_busy),  64'(busy));
    endtask

    task automatic tick_exp(input string tag, input bit v, input bit s, input bit e,
                            input logic [63:0] d, input bit r0, input bit r1, input bit busy);
        tick();
        expect_tx(tag, v, s, e, d, r0, r1, busy);
    endtask

    // Hold reset with both requesters offering SOP beats; everything must read zero.
    task automatic do_reset();
        rst = 1'b1;
        tx_ready = 1'b1;
        load(0, 1, 1, 64'hEE, 1'b0);
        load(1, 1, 1, 64'hFF, 1'b0);
        tick();
        tick_exp("rst", 0, 0, 0, 64'h0, 0, 0, 0);
        check("rst.cnt0", 64'(obs_cnt0), 64'h0);
        check("rst.cnt1", 64'(obs_cnt1), 64'h0);
        rst = 1'b0;
        load(0, 1, 0, 64'h0, 1'b0);
        load(1, 1, 0, 64'h0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tx_ready = 1'b1;
        load(0, 1, 0, 64'h0, 1'b0);
        load(1, 1, 0, 64'h0, 1'b0);
        drive();

        // Simultaneous 3-beat packets after reset: req0 first, req1 with zero gap.
        do_reset();
        load(0, 3, 3, 64'hA0, 1'b0);
        load(1, 3, 3, 64'hB0, 1'b0);
        tick_exp("a1", 1, 1, 0, 64'hA0, 1, 0, 0);
        tick_exp("a2", 1, 0, 0, 64'hA1, 1, 0, 1);
        tick_exp("a3", 1, 0, 1, 64'hA2, 1, 0, 1);
        tick_exp("a4", 1, 1, 0, 64'hB0, 0, 1, 0);
        tick_exp("a5", 1, 0, 0, 64'hB1, 0, 1, 1);
        tick_exp("a6", 1, 0, 1, 64'hB2, 0, 1, 1);
        tick_exp("a7", 0, 0, 0, 64'h0,  0, 0, 0);
        // lastGrant is now 1, so the next tie goes to req0, then alternates.
        load(0, 1, 1, 64'hC0, 1'b0);
        load(1, 1, 1, 64'hD0, 1'b0);
        tick_exp("a8",  1, 1, 1, 64'hC0, 1, 0, 0);
        tick_exp("a9",  1, 1, 1, 64'hD0, 0, 1, 0);
        tick_exp("a10", 0, 0, 0, 64'h0,  0, 0, 0);
        check("a.cnt0", 64'(obs_cnt0), STATS ? 64'd2 : 64'd0);
        check("a.cnt1", 64'(obs_cnt1), STATS ? 64'd2 : 64'd0);

        // req1 SOP arrives while req0 owns the pipe.
        do_reset();
        load(0, 3, 3, 64'h10, 1'b0);
        tick_exp("b1", 1, 1, 0, 64'h10, 1, 0, 0);
        load(1, 2, 2, 64'h20, 1'b0);
        tick_exp("b2", 1, 0, 0, 64'h11, 1, 0, 1);
        tick_exp("b3", 1, 0, 1, 64'h12, 1, 0, 1);
        tick_exp("b4", 1, 1, 0, 64'h20, 0, 1, 0);
        tick_exp("b5", 1, 0, 1, 64'h21, 0, 1, 1);
        tick_exp("b6", 0, 0, 0, 64'h0,  0, 0, 0);

        // Backpressure for 5 cycles on beat 2 of 4.
        do_reset();
        load(0, 4, 4, 64'h30, 1'b0);
        load(1, 1, 1, 64'h40, 1'b0);
        tick_exp("c1", 1, 1, 0, 64'h30, 1, 0, 0);
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick_exp("c_stall", 1, 0, 0, 64'h31, 0, 0, 1);
        tx_ready = 1'b1;
        tick_exp("c2", 1, 0, 0, 64'h31, 1, 0, 1);
        tick_exp("c3", 1, 0, 0, 64'h32, 1, 0, 1);
        tick_exp("c4", 1, 0, 1, 64'h33, 1, 0, 1);
        tick_exp("c5", 1, 1, 1, 64'h40, 0, 1, 0);
        tick_exp("c6", 0, 0, 0, 64'h0,  0, 0, 0);

        // Strict priority: req0 streams single-beat packets, req1 starves.
        sel_dut = 1'b1;
        do_reset();
        load(0, 1, 6, 64'h50, 1'b0);
        load(1, 1, 1, 64'h60, 1'b0);
        for (int k = 0; k < 6; k++) tick_exp("d_stream", 1, 1, 1, 64'h50 + 64'(k), 1, 0, 0);
        tick_exp("d7", 1, 1, 1, 64'h60, 0, 1, 0);
        tick_exp("d8", 0, 0, 0, 64'h0,  0, 0, 0);
        sel_dut = 1'b0;

        // Reset during req1 packet; the leftover non-SOP beat must not pass.
        do_reset();
        load(1, 4, 4, 64'h70, 1'b0);
        tick_exp("e1", 1, 1, 0, 64'h70, 0, 1, 0);
        tick_exp("e2", 1, 0, 0, 64'h71, 0, 1, 1);
        rst = 1'b1;
        tick_exp("e_rst", 0, 0, 0, 64'h0, 0, 0, 0);
        rst = 1'b0;
        tick_exp("e3", 0, 0, 0, 64'h0, 0, 0, 0);
        tick_exp("e4", 0, 0, 0, 64'h0, 0, 0, 0);
        load(1, 1, 0, 64'h0, 1'b0);

        // Counter wrap: 65537 single-beat req1 packets.
        do_reset();
        load(1, 1, 65537, 64'h0, 1'b0);
        tick_exp("f_first", 1, 1, 1, 64'h0, 0, 1, 0);
        for (int k = 1; k < 65537; k++) tick();
        check("f_last.data", obs_data, 64'h10000);
        tick();
        check("f_done.valid", 64'(obs_valid), 64'h0);
        check("f.cnt1", 64'(obs_cnt1), STATS ? 64'd1 : 64'd0);
        check("f.cnt0", 64'(obs_cnt0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
